// File: rtl/decoder_n_to_2n_seq.sv
// Registered N-to-2^N one-hot decoder with DECODE, SCAN, SWEEP and HOLD modes.
// Every output is derived from flops only; no input reaches an output combinationally.
module decoder_n_to_2n_seq #(
  parameter int N          = 3,
  parameter int DWELL      = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      sel,
  input  logic              start,
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      idx,
  output logic              valid,
  output logic              wrap,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam int OUT_W = 2**N;
  localparam int DW    = $clog2(DWELL) + 1;
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  IMAX  = '1;

  localparam logic [1:0] M_DEC   = 2'b00;
  localparam logic [1:0] M_SCAN  = 2'b01;
  localparam logic [1:0] M_SWEEP = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  idx_q;
  logic [DW-1:0] dcnt_q;
  logic          valid_q;
  logic          wrap_q;
  logic          busy_q;
  // Set once SCAN has taken its first (non-stepping) enabled edge.
  logic          scan_live_q;
  logic [OUT_W-1:0] onehot;

  // A pass is launched by start only when en is also high in IDLE; start is
  // ignored in RUN and DONE, and en low in RUN pauses the pass in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dcnt_q      <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      scan_live_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (mode)
        M_DEC: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          scan_live_q <= 1'b0;
          if (en) begin
            idx_q   <= sel;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        M_SCAN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (en) begin
            if (!scan_live_q || !valid_q) begin
              valid_q     <= 1'b1;
              dcnt_q      <= '0;
              scan_live_q <= 1'b1;
            end else if (dcnt_q == DLAST) begin
              idx_q  <= idx_q + N'(1);
              dcnt_q <= '0;
              if (idx_q == IMAX) wrap_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + DW'(1);
            end
          end
        end
        M_SWEEP: begin
          scan_live_q <= 1'b0;
          case (state_q)
            S_IDLE: begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              if (start && en) begin
                state_q <= S_RUN;
                idx_q   <= '0;
                dcnt_q  <= '0;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
              end
            end
            S_RUN: begin
              if (en) begin
                if (dcnt_q == DLAST) begin
                  dcnt_q <= '0;
                  idx_q  <= idx_q + N'(1);
                  if (idx_q == IMAX) begin
                    state_q <= S_DONE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    wrap_q  <= 1'b1;
                  end
                end else begin
                  dcnt_q <= dcnt_q + DW'(1);
                end
              end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
          endcase
        end
        default: begin
          // HOLD: everything frozen, wrap already defaulted low above.
        end
      endcase
    end
  end

  always_comb begin
    onehot = '0;
    if (valid_q) onehot[idx_q] = 1'b1;
  end

  assign Y         = ACTIVE_LOW ? ~onehot : onehot;
  assign idx       = idx_q;
  assign valid     = valid_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// Scoreboard bench for decoder_n_to_2n_seq: three instances (default, DWELL=2,
// ACTIVE_LOW=1) share stimulus; each expected entry names the instance it checks.
module tb_decoder_n_to_2n_seq;

  localparam logic [1:0] M_DEC = 2'b00, M_SCAN = 2'b01, M_SWEEP = 2'b10, M_HOLD = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  localparam logic [1:0] D_A = 2'd0, D_B = 2'd1, D_C = 2'd2;
  localparam logic [5:0] CK_Y = 6'd1, CK_I = 6'd2, CK_V = 6'd4, CK_W = 6'd8,
                         CK_B = 6'd16, CK_S = 6'd32, CK_ALL = 6'd63;

  typedef struct packed {
    logic [1:0] dut;
    logic [5:0] chk;
    logic [7:0] y;
    logic [2:0] idx;
    logic       v;
    logic       w;
    logic       b;
    logic [1:0] st;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic clk, rst, en, start;
  logic [1:0] mode;
  logic [2:0] sel;

  logic [7:0] y_a, y_b, y_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic v_a, v_b, v_c, w_a, w_b, w_c, b_a, b_b, b_c;
  logic [1:0] st_a, st_b, st_c;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  decoder_n_to_2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start),
    .Y(y_a), .idx(idx_a), .valid(v_a), .wrap(w_a), .busy(b_a), .fsm_state(st_a));

  decoder_n_to_2n_seq #(.N(3), .DWELL(2), .ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start),
    .Y(y_b), .idx(idx_b), .valid(v_b), .wrap(w_b), .busy(b_b), .fsm_state(st_b));

  decoder_n_to_2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start),
    .Y(y_c), .idx(idx_c), .valid(v_c), .wrap(w_c), .busy(b_c), .fsm_state(st_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] d, input logic [5:0] c, input logic [7:0] y,
                              input logic [2:0] i, input logic v, input logic w,
                              input logic b, input logic [1:0] st);
    exp_t e;
    e.dut = d; e.chk = c; e.y = y; e.idx = i; e.v = v; e.w = w; e.b = b; e.st = st;
    return e;
  endfunction

  // driver: inputs change on the falling edge, expectation is for the next rising edge
  task automatic drv(input logic r, input logic [1:0] m, input logic e_n,
                     input logic [2:0] s, input logic stt, input exp_t x);
    @(negedge clk);
    rst = r; mode = m; en = e_n; sel = s; start = stt;
    exp_q.push_back(x);
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    logic [7:0] ay;
    logic [2:0] ai;
    logic av, aw, ab;
    logic [1:0] ast;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        case (e.dut)
          D_A:     begin ay = y_a; ai = idx_a; av = v_a; aw = w_a; ab = b_a; ast = st_a; end
          D_B:     begin ay = y_b; ai = idx_b; av = v_b; aw = w_b; ab = b_b; ast = st_b; end
          default: begin ay = y_c; ai = idx_c; av = v_c; aw = w_c; ab = b_c; ast = st_c; end
        endcase
        if (e.chk[0]) cmp("Y",     ay,           e.y);
        if (e.chk[1]) cmp("idx",   {5'd0, ai},   {5'd0, e.idx});
        if (e.chk[2]) cmp("valid", {7'd0, av},   {7'd0, e.v});
        if (e.chk[3]) cmp("wrap",  {7'd0, aw},   {7'd0, e.w});
        if (e.chk[4]) cmp("busy",  {7'd0, ab},   {7'd0, e.b});
        if (e.chk[5]) cmp("fsm",   {6'd0, ast},  {6'd0, e.st});
      end
    end
  end

  initial begin
    logic [2:0] ki;
    rst = 1'b1; mode = M_DEC; en = 1'b0; sel = 3'd0; start = 1'b0;

    // reset values, both polarities
    drv(1, M_DEC, 0, 0, 0, mk(D_A, CK_ALL, 8'h00, 0, 0, 0, 0, ST_IDLE));
    drv(1, M_DEC, 0, 0, 0, mk(D_A, CK_ALL, 8'h00, 0, 0, 0, 0, ST_IDLE));
    drv(1, M_DEC, 0, 0, 0, mk(D_C, CK_ALL, 8'hFF, 0, 0, 0, 0, ST_IDLE));

    // DECODE
    drv(0, M_DEC, 1, 5, 0, mk(D_A, CK_ALL, 8'h20, 5, 1, 0, 0, ST_IDLE));
    drv(0, M_DEC, 0, 5, 0, mk(D_A, CK_ALL, 8'h00, 5, 0, 0, 0, ST_IDLE));
    drv(0, M_DEC, 1, 0, 0, mk(D_A, CK_ALL, 8'h01, 0, 1, 0, 0, ST_IDLE));
    drv(0, M_DEC, 1, 7, 0, mk(D_A, CK_ALL, 8'h80, 7, 1, 0, 0, ST_IDLE));
    drv(0, M_DEC, 1, 2, 0, mk(D_C, CK_Y | CK_I | CK_V, 8'hFB, 2, 1, 0, 0, ST_IDLE));

    // SCAN with DWELL=2 from reset, pause after the sixth enabled edge
    drv(1, M_DEC, 0, 0, 0, mk(D_B, CK_ALL, 8'h00, 0, 0, 0, 0, ST_IDLE));
    for (int k = 1; k <= 18; k++) begin
      ki = 3'((k - 1) / 2);
      drv(0, M_SCAN, 1, 0, 0,
          mk(D_B, CK_Y | CK_I | CK_V | CK_W, 8'h01 << ki, ki, 1, (k == 17), 0, ST_IDLE));
      if (k == 6) begin
        for (int p = 0; p < 3; p++)
          drv(0, M_SCAN, 0, 0, 0, mk(D_B, CK_Y | CK_I | CK_V | CK_W, 8'h04, 2, 1, 0, 0, ST_IDLE));
      end
    end

    // SWEEP full pass, second start during RUN ignored
    drv(0, M_SWEEP, 1, 0, 0, mk(D_A, CK_Y | CK_V | CK_W | CK_B | CK_S, 8'h00, 0, 0, 0, 0, ST_IDLE));
    drv(0, M_SWEEP, 0, 0, 1, mk(D_A, CK_Y | CK_V | CK_B | CK_S, 8'h00, 0, 0, 0, 0, ST_IDLE));
    drv(0, M_SWEEP, 1, 0, 1, mk(D_A, CK_ALL, 8'h01, 0, 1, 0, 1, ST_RUN));
    for (int i = 1; i < 8; i++) begin
      ki = 3'(i);
      drv(0, M_SWEEP, 1, 0, (i == 3), mk(D_A, CK_ALL, 8'h01 << ki, ki, 1, 0, 1, ST_RUN));
    end
    drv(0, M_SWEEP, 1, 0, 0, mk(D_A, CK_Y | CK_V | CK_W | CK_B | CK_S, 8'h00, 0, 0, 1, 0, ST_DONE));
    drv(0, M_SWEEP, 1, 0, 0, mk(D_A, CK_Y | CK_V | CK_W | CK_B | CK_S, 8'h00, 0, 0, 0, 0, ST_IDLE));

    // reset mid-pass at idx 4
    drv(0, M_SWEEP, 1, 0, 1, mk(D_A, CK_ALL, 8'h01, 0, 1, 0, 1, ST_RUN));
    for (int i = 1; i <= 4; i++) begin
      ki = 3'(i);
      drv(0, M_SWEEP, 1, 0, 0, mk(D_A, CK_ALL, 8'h01 << ki, ki, 1, 0, 1, ST_RUN));
    end
    drv(1, M_SWEEP, 1, 0, 0, mk(D_A, CK_ALL, 8'h00, 0, 0, 0, 0, ST_IDLE));
    drv(0, M_SWEEP, 1, 0, 0, mk(D_A, CK_Y | CK_V | CK_B | CK_S, 8'h00, 0, 0, 0, 0, ST_IDLE));

    // pause in RUN, abort into DECODE at idx 3, then HOLD
    drv(0, M_SWEEP, 1, 0, 1, mk(D_A, CK_ALL, 8'h01, 0, 1, 0, 1, ST_RUN));
    drv(0, M_SWEEP, 0, 0, 0, mk(D_A, CK_ALL, 8'h01, 0, 1, 0, 1, ST_RUN));
    for (int i = 1; i <= 3; i++) begin
      ki = 3'(i);
      drv(0, M_SWEEP, 1, 0, 0, mk(D_A, CK_ALL, 8'h01 << ki, ki, 1, 0, 1, ST_RUN));
    end
    drv(0, M_DEC, 1, 6, 0, mk(D_A, CK_ALL, 8'h40, 6, 1, 0, 0, ST_IDLE));
    for (int h = 0; h < 5; h++)
      drv(0, M_HOLD, h[0], 3'(h), (h == 2), mk(D_A, CK_ALL, 8'h40, 6, 1, 0, 0, ST_IDLE));

    // SCAN from idx 6 with DWELL=1: first edge no step, then wrap 7 -> 0
    drv(0, M_SCAN, 1, 0, 0, mk(D_A, CK_ALL, 8'h40, 6, 1, 0, 0, ST_IDLE));
    drv(0, M_SCAN, 1, 0, 0, mk(D_A, CK_ALL, 8'h80, 7, 1, 0, 0, ST_IDLE));
    drv(0, M_SCAN, 1, 0, 0, mk(D_A, CK_ALL, 8'h01, 0, 1, 1, 0, ST_IDLE));
    drv(0, M_HOLD, 1, 0, 0, mk(D_A, CK_ALL, 8'h01, 0, 1, 0, 0, ST_IDLE));
    drv(0, M_SCAN, 1, 0, 0, mk(D_A, CK_ALL, 8'h02, 1, 1, 0, 0, ST_IDLE));

    @(negedge clk);
    rst = 1'b0; mode = M_HOLD; en = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
